// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage datapath and hazard_ctrl.
// The datapath (master) reports hazard sources; the controller (slave) returns hold/flush controls.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       IFID_rs_i;
    logic [4:0]       IFID_rt_i;
    logic             IFID_use_rt_i;
    logic             IDEX_memread_i;
    logic [4:0]       IDEX_rt_i;
    logic             branch_taken_i;
    logic             EXMEM_memaccess_i;
    logic             dmem_ready_i;
    logic             PC_write_o;
    logic             IFID_write_o;
    logic             IFID_flush_o;
    logic             IDEX_bubble_o;
    logic             pipe_hold_o;
    logic             mem_err_o;
    logic [CNT_W-1:0] stall_cycles_o;

    modport master (
        output IFID_rs_i, IFID_rt_i, IFID_use_rt_i, IDEX_memread_i, IDEX_rt_i,
               branch_taken_i, EXMEM_memaccess_i, dmem_ready_i,
        input  PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
               pipe_hold_o, mem_err_o, stall_cycles_o
    );

    modport slave (
        input  IFID_rs_i, IFID_rt_i, IFID_use_rt_i, IDEX_memread_i, IDEX_rt_i,
               branch_taken_i, EXMEM_memaccess_i, dmem_ready_i,
        output PC_write_o, IFID_write_o, IFID_flush_o, IDEX_bubble_o,
               pipe_hold_o, mem_err_o, stall_cycles_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush controller: load-use stalls, taken-branch flushes, and back-end freeze
// while a variable-latency data memory access is outstanding, with timeout and stall counter.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input logic          clk_i,
    input logic          rst_i,
    hazard_ctrl_if.slave hz
);
    localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_e;

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              lu, mw, freeze, stall;

    assign lu = hz.IDEX_memread_i && (hz.IDEX_rt_i != 5'd0) &&
                ((hz.IDEX_rt_i == hz.IFID_rs_i) ||
                 (hz.IFID_use_rt_i && (hz.IDEX_rt_i == hz.IFID_rt_i)));
    assign mw = hz.EXMEM_memaccess_i && !hz.dmem_ready_i;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        freeze  = 1'b0;
        stall   = 1'b0;
        unique case (state_q)
            RUN: begin
                if (mw) begin
                    freeze  = 1'b1;
                    wait_d  = WAIT_W'(1);
                    state_d = MEMWAIT;
                end else begin
                    stall = lu;
                end
            end
            MEMWAIT: begin
                if (hz.dmem_ready_i) begin
                    stall   = lu;
                    wait_d  = '0;
                    state_d = RUN;
                end else if (wait_q == WAIT_LAST) begin
                    freeze  = 1'b1;
                    state_d = ERR;
                end else begin
                    freeze = 1'b1;
                    wait_d = wait_q + 1'b1;
                end
            end
            ERR:     freeze = 1'b1;
            default: state_d = RUN;
        endcase
    end

    // Priority freeze > stall > flush; a held branch flushes on its first normal cycle.
    assign hz.PC_write_o     = !freeze && !stall;
    assign hz.IFID_write_o   = !freeze && !stall;
    assign hz.IDEX_bubble_o  = !freeze && stall;
    assign hz.pipe_hold_o    = freeze;
    assign hz.IFID_flush_o   = !freeze && !stall && hz.branch_taken_i;
    assign hz.mem_err_o      = (state_q == ERR);
    assign hz.stall_cycles_o = cnt_q;

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            if ((freeze || stall) && (cnt_q != {CNT_W{1'b1}}))
                cnt_q <= cnt_q + 1'b1;
        end
    end
endmodule
